write_burst_submodule: RTL and testbench
========================================

# write_burst_submodule

Parametrised successor to the single-beat write engine. Accepts one start request with a base address and a beat count, pulls write data from the supermodule one word at a time, and issues one address/data/response exchange per beat on the memory interface. Address may increment per beat or stay fixed (FIFO/register-port mode); responses are accumulated into a sticky error, with optional abort on first error. Sits between the sort-control supermodule and the memory write channels.

## Interface

- DATA_W, 32, width of w_data and data
- ADDR_W, 4, width of aw_address and addr (word address)
- MAX_LEN, 8, maximum beats per request, power of two, ≥2
- LEN_W, $clog2(MAX_LEN), width of len
- ABORT_ON_ERR, 0, 1: stop after the first beat whose b_resp=1

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- aw_valid  out  1  write address valid
- aw_ready  in  1  write address accepted
- aw_address  out  ADDR_W  write address
- w_valid  out  1  write data valid
- w_ready  in  1  write data accepted
- w_data  out  DATA_W  write data
- b_valid  in  1  write response valid
- b_ready  out  1  write response accepted
- b_resp  in  1  1 = beat failed
- start  in  1  request pulse, sampled only in IDLE
- addr  in  ADDR_W  base address, captured with start
- len  in  LEN_W  beats minus one, captured with start
- incr  in  1  1: address +1 per beat; 0: fixed address; captured with start
- data  in  DATA_W  next beat data
- data_valid  in  1  data holds a beat
- data_ready  out  1  block takes data this cycle
- busy  out  1  high from cycle after start until done cycle inclusive
- done  out  1  one-cycle completion pulse
- resp  out  1  sticky OR of b_resp over the request; valid with done, held until next accepted start
- beat_cnt  out  LEN_W+1  beats with completed B handshake in current request

## Operation

- States: IDLE, LOAD, XFER, RESP, DONE.
- IDLE: start=1 → capture addr/len/incr, clear resp and beat_cnt, → LOAD. start in any other state ignored.
- LOAD: data_ready=1. data_valid=1 → register data into w_data, aw_address = current address, → XFER.
- XFER: aw_valid and w_valid high from first XFER cycle. Each drops the cycle after its own handshake (independent; may complete same cycle or either order, any delay). Both complete → RESP next cycle.
- RESP: b_ready=1. b_valid=1 → resp |= b_resp, beat_cnt+1, address += incr (mod 2^ADDR_W, wrap to 0). If beat_cnt+1 == len+1, or (ABORT_ON_ERR and b_resp) → DONE, else → LOAD.
- DONE: done=1 for one cycle → IDLE. resp and beat_cnt hold until next start.
- w_data and aw_address stable while their valid is high.
- data_ready only in LOAD; b_ready only in RESP; never overlap.

## Timing

- Reset (async, immediate): state IDLE; aw_valid, w_valid, b_ready, data_ready, busy, done, resp = 0; w_data, aw_address, beat_cnt = 0. Reset mid-request abandons it; no done issued.
- start at edge N → LOAD at N+1 (busy=1).
- Minimum 3 cycles per beat (LOAD, XFER, RESP) with data_valid, aw_ready, w_ready, b_valid held high; N-beat request: done 3N+1 cycles after start edge.
- done asserted cycle after final B handshake.
- start asserted during DONE ignored; earliest accepted start is first IDLE cycle.

## Test plan

- Single beat: addr=3, len=0, incr=1, data=0xDEADBEEF, all readies high → aw_address=3, w_data=0xDEADBEEF, done 4 cycles after start, resp=0, beat_cnt=1.
- Burst with wrap: ADDR_W=4, addr=14, len=3, incr=1, data 1..4 → addresses 14,15,0,1 with data 1,2,3,4; done at cycle 13; beat_cnt=4.
- Fixed mode + skewed handshakes: addr=5, len=2, incr=0; w_ready 2 cycles before aw_ready on beat 0, aw_ready 3 cycles before w_ready on beat 1 → all beats to 5, w_valid/aw_valid drop independently, no RESP before both handshakes.
- Error accumulate vs abort: len=3, b_resp=1 on beat 1 only → ABORT_ON_ERR=0: 4 beats, resp=1; ABORT_ON_ERR=1: done after beat 1, beat_cnt=2, resp=1.
- Backpressure and stray start: data_valid low 5 cycles in LOAD, b_valid delayed 4 cycles, start pulsed mid-request → data_ready held, no extra transfers, start ignored, single done.
- Reset mid-XFER: assert rst while aw_valid=1 → all outputs 0 same cycle, no done; fresh request afterward completes normally.

Source files
------------

// File: rtl/write_burst_submodule.sv
// Multi-beat write engine: fetches one data word per beat from the supermodule and runs
// an AW/W/B exchange per beat, with incrementing or fixed addressing and a sticky error.
module write_burst_submodule #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 4,
   parameter int MAX_LEN      = 8,
   parameter int LEN_W        = $clog2(MAX_LEN),
   parameter bit ABORT_ON_ERR = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              aw_valid,
   input  logic              aw_ready,
   output logic [ADDR_W-1:0] aw_address,
   output logic              w_valid,
   input  logic              w_ready,
   output logic [DATA_W-1:0] w_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic              b_resp,
   input  logic              start,
   input  logic [ADDR_W-1:0] addr,
   input  logic [LEN_W-1:0]  len,
   input  logic              incr,
   input  logic [DATA_W-1:0] data,
   input  logic              data_valid,
   output logic              data_ready,
   output logic              busy,
   output logic              done,
   output logic              resp,
   output logic [LEN_W:0]    beat_cnt
);

   typedef enum logic [2:0] {IDLE, LOAD, XFER, RESP, DONE} state_t;

   state_t            state_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [LEN_W-1:0]  len_reg;
   logic              incr_reg;

   logic aw_fire;
   logic w_fire;
   logic aw_clear;
   logic w_clear;
   logic last_beat;

   assign aw_fire   = aw_valid && aw_ready;
   assign w_fire    = w_valid && w_ready;
   // A channel is finished once its valid has dropped or it handshakes this cycle.
   assign aw_clear  = !aw_valid || aw_ready;
   assign w_clear   = !w_valid || w_ready;
   assign last_beat = (beat_cnt == {1'b0, len_reg});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         addr_reg   <= '0;
         len_reg    <= '0;
         incr_reg   <= 1'b0;
         aw_valid   <= 1'b0;
         aw_address <= '0;
         w_valid    <= 1'b0;
         w_data     <= '0;
         b_ready    <= 1'b0;
         data_ready <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         resp       <= 1'b0;
         beat_cnt   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  addr_reg   <= addr;
                  len_reg    <= len;
                  incr_reg   <= incr;
                  resp       <= 1'b0;
                  beat_cnt   <= '0;
                  data_ready <= 1'b1;
                  busy       <= 1'b1;
                  state_reg  <= LOAD;
               end
            end
            LOAD: begin
               if (data_valid) begin
                  w_data     <= data;
                  aw_address <= addr_reg;
                  aw_valid   <= 1'b1;
                  w_valid    <= 1'b1;
                  data_ready <= 1'b0;
                  state_reg  <= XFER;
               end
            end
            XFER: begin
               if (aw_fire) aw_valid <= 1'b0;
               if (w_fire)  w_valid  <= 1'b0;
               if (aw_clear && w_clear) begin
                  b_ready   <= 1'b1;
                  state_reg <= RESP;
               end
            end
            RESP: begin
               if (b_valid) begin
                  resp     <= resp | b_resp;
                  beat_cnt <= beat_cnt + 1'b1;
                  addr_reg <= addr_reg + ADDR_W'(incr_reg);
                  b_ready  <= 1'b0;
                  // beat_cnt still holds the pre-increment count here.
                  if (last_beat || (ABORT_ON_ERR && b_resp)) begin
                     done      <= 1'b1;
                     state_reg <= DONE;
                  end else begin
                     data_ready <= 1'b1;
                     state_reg  <= LOAD;
                  end
               end
            end
            DONE: begin
               done      <= 1'b0;
               busy      <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_write_burst_submodule.sv
// Scoreboard bench: drivers push expected AW/W/done records, negedge-aligned monitors pop and compare.
module tb_write_burst_submodule;

   logic        clk;
   logic        rst;
   logic        aw_ready, w_ready, b_valid, b_resp;
   logic        start, incr, data_valid;
   logic [3:0]  addr;
   logic [2:0]  len;
   logic [31:0] data;

   logic        aw_valid, w_valid, b_ready, data_ready, busy, done, resp;
   logic [3:0]  aw_address;
   logic [31:0] w_data;
   logic [3:0]  beat_cnt;

   logic        ab_aw_valid, ab_w_valid, ab_b_ready, ab_data_ready, ab_busy, ab_done, ab_resp;
   logic [3:0]  ab_aw_address;
   logic [31:0] ab_w_data;
   logic [3:0]  ab_beat_cnt;

   write_burst_submodule #(.DATA_W(32), .ADDR_W(4), .MAX_LEN(8), .ABORT_ON_ERR(1'b0)) dut (
      .clk(clk), .rst(rst),
      .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_address(aw_address),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
      .start(start), .addr(addr), .len(len), .incr(incr),
      .data(data), .data_valid(data_valid), .data_ready(data_ready),
      .busy(busy), .done(done), .resp(resp), .beat_cnt(beat_cnt)
   );

   write_burst_submodule #(.DATA_W(32), .ADDR_W(4), .MAX_LEN(8), .ABORT_ON_ERR(1'b1)) dut_ab (
      .clk(clk), .rst(rst),
      .aw_valid(ab_aw_valid), .aw_ready(aw_ready), .aw_address(ab_aw_address),
      .w_valid(ab_w_valid), .w_ready(w_ready), .w_data(ab_w_data),
      .b_valid(b_valid), .b_ready(ab_b_ready), .b_resp(b_resp),
      .start(start), .addr(addr), .len(len), .incr(incr),
      .data(data), .data_valid(data_valid), .data_ready(ab_data_ready),
      .busy(ab_busy), .done(ab_done), .resp(ab_resp), .beat_cnt(ab_beat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic r;
      int   cnt;
      int   lat;
   } done_t;

   logic [3:0]  q_aw[$];
   logic [31:0] q_w[$];
   done_t       q_done[$];
   done_t       q_ab[$];

   int checks = 0;
   int fails  = 0;
   int start_cyc = 0;
   int exp_dones = 0;
   int done_seen = 0;
   int ab_done_seen = 0;

   logic [31:0] beat_data[8];
   logic [3:0]  exp_aw[8];
   int          d_dly[8], aw_dly[8], w_dly[8], b_dly[8];
   logic        b_err[8];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Main-DUT monitor: pops expectations on handshakes and done, checks protocol invariants.
   logic        prev_aw_hold = 1'b0, prev_w_hold = 1'b0;
   logic [3:0]  prev_aw_addr = '0;
   logic [31:0] prev_w_data = '0;
   always @(negedge clk) begin
      #2;
      if (!rst) begin
         if (aw_valid && aw_ready) begin
            if (q_aw.size() == 0) check("aw_unexpected", {60'd0, aw_address}, 64'hFFFF);
            else check("aw_address", {60'd0, aw_address}, {60'd0, q_aw.pop_front()});
         end
         if (w_valid && w_ready) begin
            if (q_w.size() == 0) check("w_unexpected", {32'd0, w_data}, 64'hFFFF_FFFF_FFFF);
            else check("w_data", {32'd0, w_data}, {32'd0, q_w.pop_front()});
         end
         if (prev_aw_hold && aw_valid) check("aw_address_stable", {60'd0, aw_address}, {60'd0, prev_aw_addr});
         if (prev_w_hold && w_valid)   check("w_data_stable", {32'd0, w_data}, {32'd0, prev_w_data});
         prev_aw_hold = aw_valid && !aw_ready;
         prev_w_hold  = w_valid && !w_ready;
         prev_aw_addr = aw_address;
         prev_w_data  = w_data;
         if (b_ready || data_ready)
            check("handshake_exclusive", {61'd0, data_ready, aw_valid | w_valid, 1'b0}, {61'd0, 1'b0, 1'b0, 1'b0} | {61'd0, data_ready & ~b_ready, 2'b00});
         if (done) begin
            done_seen++;
            check("busy_with_done", {63'd0, busy}, 64'd1);
            if (q_done.size() == 0) check("done_unexpected", 64'd1, 64'd0);
            else begin
               done_t e;
               e = q_done.pop_front();
               check("done_resp", {63'd0, resp}, {63'd0, e.r});
               check("done_beat_cnt", {60'd0, beat_cnt}, 64'(e.cnt));
               check("done_latency", 64'(cyc - start_cyc), 64'(e.lat));
            end
         end
         if (ab_done) begin
            ab_done_seen++;
            if (q_ab.size() == 0) check("ab_done_unexpected", 64'd1, 64'd0);
            else begin
               done_t e;
               e = q_ab.pop_front();
               check("ab_done_resp", {63'd0, ab_resp}, {63'd0, e.r});
               check("ab_done_beat_cnt", {60'd0, ab_beat_cnt}, 64'(e.cnt));
               check("ab_done_latency", 64'(cyc - start_cyc), 64'(e.lat));
            end
         end
      end else begin
         prev_aw_hold = 1'b0;
         prev_w_hold  = 1'b0;
      end
   end

   function automatic logic sig(input int sel);
      case (sel)
         0: return data_ready;
         1: return aw_valid;
         default: return b_ready;
      endcase
   endfunction

   task automatic wait_for(input int sel, input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         if (sig(sel)) seen = 1'b1;
         else @(negedge clk);
      end
      if (!seen) begin
         checks++;
         fails++;
         $display("FAIL timeout_%s: got 0 expected 1 within 60 cycles", nm);
      end
   endtask

   task automatic set_beat(input int k, input logic [31:0] d, input logic [3:0] a, input int dd,
                           input int awd, input int wd, input int bd, input logic err);
      beat_data[k] = d;
      exp_aw[k]    = a;
      d_dly[k]     = dd;
      aw_dly[k]    = awd;
      w_dly[k]     = wd;
      b_dly[k]     = bd;
      b_err[k]     = err;
   endtask

   task automatic run_req(input logic [3:0] a, input logic [2:0] l, input logic inc,
                          input logic e_r, input int e_cnt, input int e_lat,
                          input logic ab_r, input int ab_cnt, input int ab_lat);
      done_t e;
      @(negedge clk);
      start = 1'b1; addr = a; len = l; incr = inc;
      start_cyc = cyc;
      for (int k = 0; k <= int'(l); k++) begin
         q_aw.push_back(exp_aw[k]);
         q_w.push_back(beat_data[k]);
      end
      e.r = e_r; e.cnt = e_cnt; e.lat = e_lat;
      q_done.push_back(e);
      e.r = ab_r; e.cnt = ab_cnt; e.lat = ab_lat;
      q_ab.push_back(e);
      exp_dones++;
      $display("request addr=%0d len=%0d incr=%0d", a, l, inc);
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k <= int'(l); k++) begin
         wait_for(0, "data_ready");
         repeat (d_dly[k]) @(negedge clk);
         data_valid = 1'b1; data = beat_data[k];
         @(negedge clk);
         data_valid = 1'b0;
         wait_for(1, "aw_valid");
         fork
            begin
               repeat (aw_dly[k]) @(negedge clk);
               aw_ready = 1'b1;
               @(negedge clk);
               aw_ready = 1'b0;
            end
            begin
               repeat (w_dly[k]) @(negedge clk);
               w_ready = 1'b1;
               @(negedge clk);
               w_ready = 1'b0;
            end
         join
         wait_for(2, "b_ready");
         repeat (b_dly[k]) @(negedge clk);
         b_valid = 1'b1; b_resp = b_err[k];
         @(negedge clk);
         b_valid = 1'b0; b_resp = 1'b0;
         $display("beat %0d addr=%0d data=0x%08h b_resp=%0d", k, exp_aw[k], beat_data[k], b_err[k]);
      end
   endtask

   initial begin
      rst = 1'b1;
      aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 0;
      start = 0; incr = 0; data_valid = 0; addr = '0; len = '0; data = '0;
      #7;
      check("reset_outputs", {aw_valid, w_valid, b_ready, data_ready, busy, done, resp, aw_address, w_data, beat_cnt}, 64'd0);
      check("ab_reset_outputs", {ab_aw_valid, ab_w_valid, ab_b_ready, ab_data_ready, ab_busy, ab_done, ab_resp, ab_aw_address, ab_w_data, ab_beat_cnt}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Single beat, all readies immediate.
      set_beat(0, 32'hDEADBEEF, 4'd3, 0, 0, 0, 0, 1'b0);
      run_req(4'd3, 3'd0, 1'b1, 1'b0, 1, 4, 1'b0, 1, 4);

      // Four beats wrapping past the top of the address space.
      set_beat(0, 32'd1, 4'd14, 0, 0, 0, 0, 1'b0);
      set_beat(1, 32'd2, 4'd15, 0, 0, 0, 0, 1'b0);
      set_beat(2, 32'd3, 4'd0,  0, 0, 0, 0, 1'b0);
      set_beat(3, 32'd4, 4'd1,  0, 0, 0, 0, 1'b0);
      run_req(4'd14, 3'd3, 1'b1, 1'b0, 4, 13, 1'b0, 4, 13);

      // Fixed address, skewed AW/W handshakes.
      set_beat(0, 32'hA0, 4'd5, 0, 2, 0, 0, 1'b0);
      set_beat(1, 32'hA1, 4'd5, 0, 0, 3, 0, 1'b0);
      set_beat(2, 32'hA2, 4'd5, 0, 0, 0, 0, 1'b0);
      run_req(4'd5, 3'd2, 1'b0, 1'b0, 3, 15, 1'b0, 3, 15);

      // Error on beat 1: accumulate on one instance, abort on the other.
      set_beat(0, 32'd11, 4'd8,  0, 0, 0, 0, 1'b0);
      set_beat(1, 32'd12, 4'd9,  0, 0, 0, 0, 1'b1);
      set_beat(2, 32'd13, 4'd10, 0, 0, 0, 0, 1'b0);
      set_beat(3, 32'd14, 4'd11, 0, 0, 0, 0, 1'b0);
      run_req(4'd8, 3'd3, 1'b1, 1'b1, 4, 13, 1'b1, 2, 7);

      // Backpressure on data and response, stray start mid-request, start during DONE.
      set_beat(0, 32'h55, 4'd2, 5, 0, 0, 4, 1'b0);
      set_beat(1, 32'h66, 4'd3, 0, 0, 0, 0, 1'b0);
      fork
         run_req(4'd2, 3'd1, 1'b1, 1'b0, 2, 16, 1'b0, 2, 16);
         begin
            repeat (3) @(negedge clk);
            start = 1'b1; addr = 4'hF; len = 3'd0;
            @(negedge clk);
            start = 1'b0;
         end
      join
      check("data_ready_dropped", {63'd0, data_ready}, 64'd0);
      start = 1'b1; addr = 4'd6; len = 3'd0;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("start_in_done_ignored", {62'd0, busy, ab_busy}, 64'd0);

      // Reset while the address phase is pending.
      @(negedge clk);
      start = 1'b1; addr = 4'd9; len = 3'd1; incr = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_for(0, "data_ready");
      data_valid = 1'b1; data = 32'h99;
      @(negedge clk);
      data_valid = 1'b0;
      check("aw_valid_before_reset", {63'd0, aw_valid}, 64'd1);
      #3 rst = 1'b1;
      #1;
      check("reset_mid_xfer", {aw_valid, w_valid, b_ready, data_ready, busy, done, resp, aw_address, w_data, beat_cnt}, 64'd0);
      check("ab_reset_mid_xfer", {ab_aw_valid, ab_w_valid, ab_b_ready, ab_data_ready, ab_busy, ab_done, ab_resp, ab_aw_address, ab_w_data, ab_beat_cnt}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      $display("reset applied mid-request");

      set_beat(0, 32'h77, 4'd7, 0, 0, 0, 0, 1'b0);
      set_beat(1, 32'h88, 4'd7, 0, 0, 0, 0, 1'b0);
      run_req(4'd7, 3'd1, 1'b0, 1'b0, 2, 7, 1'b0, 2, 7);

      repeat (4) @(negedge clk);
      check("aw_queue_empty", 64'(q_aw.size()), 64'd0);
      check("w_queue_empty", 64'(q_w.size()), 64'd0);
      check("done_queue_empty", 64'(q_done.size()), 64'd0);
      check("ab_queue_empty", 64'(q_ab.size()), 64'd0);
      check("done_count", 64'(done_seen), 64'(exp_dones));
      check("ab_done_count", 64'(ab_done_seen), 64'(exp_dones));
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
